// File: rtl/traffic_pkg.sv
// Shared timing constants for the traffic controller slice.
// These defaults are common to traffic_control, the timer/sense front end and the benches.
package traffic_pkg;

  // Default timer and sensor conditioning constants
  localparam int TMR_PRESCALE    = 32'sd4;
  localparam int TMR_SHORT_TICKS = 32'sd3;
  localparam int TMR_LONG_TICKS  = 32'sd10;
  localparam int SNS_DEBOUNCE    = 32'sd4;

  // Bits needed to hold 0..value-1, never less than one bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < value) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/traffic_timer_sense_sync_debounce.sv
// sync_debounce: two-flop synchroniser followed by a level debouncer.
// The output only changes after the synchronised input has held a new level
// for DEBOUNCE consecutive clock cycles; shorter excursions are discarded.
module sync_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic            meta_r;
  logic            sync_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            dout_r;
  logic [DB_W-1:0] db_cnt_nxt_s;
  logic            dout_nxt_s;

  // Debounce decision: count cycles of disagreement, flip output once the count completes
  always_comb begin
    db_cnt_nxt_s = db_cnt_r;
    dout_nxt_s   = dout_r;
    if (sync_r == dout_r) begin
      db_cnt_nxt_s = {DB_W{1'b0}};
    end else if (db_cnt_r == DB_W'(DEBOUNCE - 1)) begin
      dout_nxt_s   = sync_r;
      db_cnt_nxt_s = {DB_W{1'b0}};
    end else begin
      db_cnt_nxt_s = db_cnt_r + DB_W'(1'b1);
    end
  end

  // Synchroniser flops, debounce counter and registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      db_cnt_r <= {DB_W{1'b0}};
      dout_r   <= 1'b0;
    end else begin
      meta_r   <= din;
      sync_r   <= meta_r;
      db_cnt_r <= db_cnt_nxt_s;
      dout_r   <= dout_nxt_s;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/traffic_timer_sense.sv
// traffic_timer_sense: timing and sensing front end for traffic_control.
// ST restarts a prescaled tick counter; TS/TL flag the short/long expiry points.
// car_raw is synchronised and debounced into the car-present flag C.
// Optional feature macro TIMER_HOLD_EN adds a 'hold' input that freezes the timer
// (restart by ST still wins); without it the timer never freezes.
module traffic_timer_sense
  import traffic_pkg::*;
#(
  parameter int PRESCALE    = TMR_PRESCALE,
  parameter int SHORT_TICKS = TMR_SHORT_TICKS,
  parameter int LONG_TICKS  = TMR_LONG_TICKS,
  parameter int DEBOUNCE    = SNS_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic ST,
  input  logic car_raw,
`ifdef TIMER_HOLD_EN
  input  logic hold,
`endif
  output logic TS,
  output logic TL,
  output logic C
);

  localparam int CNT_W = $clog2(LONG_TICKS + 1);
  localparam int PRE_W = clog2_min1(PRESCALE);

  logic [PRE_W-1:0] pre_cnt_r;
  logic [CNT_W-1:0] tick_cnt_r;
  logic             ts_r;
  logic             tl_r;
  logic [PRE_W-1:0] pre_cnt_nxt_s;
  logic [CNT_W-1:0] tick_cnt_nxt_s;
  logic             tick_s;
  logic             hold_s;

`ifdef TIMER_HOLD_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  // Timer next state: restart beats hold, hold beats counting; tick count saturates at LONG_TICKS
  always_comb begin
    tick_s         = (pre_cnt_r == PRE_W'(PRESCALE - 1));
    pre_cnt_nxt_s  = pre_cnt_r;
    tick_cnt_nxt_s = tick_cnt_r;
    if (ST) begin
      pre_cnt_nxt_s  = {PRE_W{1'b0}};
      tick_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (hold_s) begin
      pre_cnt_nxt_s  = pre_cnt_r;
      tick_cnt_nxt_s = tick_cnt_r;
    end else if (tick_s) begin
      pre_cnt_nxt_s = {PRE_W{1'b0}};
      if (tick_cnt_r < CNT_W'(LONG_TICKS)) begin
        tick_cnt_nxt_s = tick_cnt_r + CNT_W'(1'b1);
      end else begin
        tick_cnt_nxt_s = tick_cnt_r;
      end
    end else begin
      pre_cnt_nxt_s = pre_cnt_r + PRE_W'(1'b1);
    end
  end

  // Timer state and expiry flags, flags loaded from the next-state count
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_r  <= {PRE_W{1'b0}};
      tick_cnt_r <= {CNT_W{1'b0}};
      ts_r       <= 1'b0;
      tl_r       <= 1'b0;
    end else begin
      pre_cnt_r  <= pre_cnt_nxt_s;
      tick_cnt_r <= tick_cnt_nxt_s;
      ts_r       <= (tick_cnt_nxt_s >= CNT_W'(SHORT_TICKS));
      tl_r       <= (tick_cnt_nxt_s >= CNT_W'(LONG_TICKS));
    end
  end

  assign TS = ts_r;
  assign TL = tl_r;

  sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_car_db (
    .clk   (clk),
    .reset (reset),
    .din   (car_raw),
    .dout  (C)
  );

endmodule

// File: tb/tb_traffic_timer_sense.sv
// Self-checking bench for traffic_timer_sense (PRESCALE=2, SHORT=3, LONG=5, DEBOUNCE=4).
// Timer expectations come from an elapsed-edge count since the last restart;
// car-path expectations come from a hand-derived vector table.
module tb_traffic_timer_sense;

  localparam int PRESCALE    = 2;
  localparam int SHORT_TICKS = 3;
  localparam int LONG_TICKS  = 5;
  localparam int DEBOUNCE    = 4;
  localparam int TS_EDGES    = PRESCALE * SHORT_TICKS;
  localparam int TL_EDGES    = PRESCALE * LONG_TICKS;

  logic clk = 1'b0;
  logic reset;
  logic st;
  logic car_raw;
`ifdef TIMER_HOLD_EN
  logic hold;
`endif
  logic ts;
  logic tl;
  logic c;

  always #5 clk = ~clk;

  traffic_timer_sense #(
    .PRESCALE    (PRESCALE),
    .SHORT_TICKS (SHORT_TICKS),
    .LONG_TICKS  (LONG_TICKS),
    .DEBOUNCE    (DEBOUNCE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ST      (st),
    .car_raw (car_raw),
`ifdef TIMER_HOLD_EN
    .hold    (hold),
`endif
    .TS      (ts),
    .TL      (tl),
    .C       (c)
  );

  typedef struct packed {
    logic ts;
    logic tl;
    logic c;
    logic chk_c;
  } exp_t;

  typedef struct packed {
    logic rst;
    logic car;
    logic c;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   el    = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, push expectation, compare after the edge
  task automatic cycle(input logic r, input logic s, input logic car, input logic h,
                       input logic exp_c, input logic chk_c, input string tag);
    exp_t e;
    exp_t got;
    reset   = r;
    st      = s;
    car_raw = car;
`ifdef TIMER_HOLD_EN
    hold    = h;
`endif
    if (r || s) el = 0;
    else if (!h && el < 1000) el++;
    e.ts    = (el >= TS_EDGES);
    e.tl    = (el >= TL_EDGES);
    e.c     = exp_c;
    e.chk_c = chk_c;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = sb_q.pop_front();
    chk({tag, "_TS"}, ts, got.ts);
    chk({tag, "_TL"}, tl, got.tl);
    if (got.chk_c) chk({tag, "_C"}, c, got.c);
  endtask

  vec_t tab[36];

  initial begin
    tab = '{
      // 3-cycle glitch, then quiet: C never moves
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0},
      // steady rise: C=1 on 6th edge
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b1},
      // steady fall: C=0 on 6th edge
      '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0},
      // rise interrupted by reset, debounce restarts from scratch
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1}
    };

    reset   = 1'b1;
    st      = 1'b0;
    car_raw = 1'b0;
`ifdef TIMER_HOLD_EN
    hold    = 1'b0;
`endif

    // 1: reset for two cycles, then free-run to TS/TL
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst");
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "run");

    // 2: single-cycle ST with TL set
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "stpulse");
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_st");

    // 3: ST held four cycles in the middle of a count
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "st_a");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "st_held");
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "after_held");

    // 4: long idle, flags saturate and never wrap
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sat");

    // 5: car path vectors
    for (int i = 0; i < 36; i++) cycle(tab[i].rst, 1'b0, tab[i].car, 1'b0, tab[i].c, 1'b1, "car");

`ifdef TIMER_HOLD_EN
    // 6: hold at tick_cnt=2 delays expiry; ST overrides hold
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "h_st");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "h_pre");
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "h_hold");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "h_run");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "h_st_over");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "h_frozen");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "h_end");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
